par_mem_resp: RTL and testbench

- Parity-protected byte memory responder on the single-cycle write/read strobe bus driven by the memory test initiators.
- Accepts 8-bit writes at a 16-bit address and stores each byte with a generated even-parity bit.
- Returns {parity, data} as 9 bits after a fixed, parameterised read latency.
- Checks stored parity on every read, counts errors, and flags uninitialised reads and write/read collisions.

---
 rtl/par_mem_resp.sv | 166 ++++++++++++++++
 tb/tb_par_mem_resp.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/par_mem_resp.sv
// Parity-protected byte memory responder: stores {parity, data}, returns it after RD_LAT cycles.
// Optional PAR_MEM_INJECT_EN adds inj_par, which stores inverted parity for error-path testing.
module par_mem_resp #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        data_in,
`ifdef PAR_MEM_INJECT_EN
  input  logic              inj_par,
`endif
  output logic [8:0]        data_out,
  output logic              rd_valid,
  output logic              par_err,
  output logic [CNT_W-1:0]  err_count,
  output logic              uninit_rd,
  output logic              addr_err,
  output logic              collision
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic             in_rng;
  logic             wr_acc;
  logic             rd_acc;
  logic             inj_bit;
  logic [IDX_W-1:0] wr_idx;
  logic [8:0]       wr_word;

  logic [8:0]       mem_q [DEPTH];
  logic [DEPTH-1:0] written_q;

  logic             fin_v;
  logic             fin_ok;
  logic [IDX_W-1:0] fin_idx;

  logic             fwd;
  logic [8:0]       rd_word;
  logic             rd_wr;
  logic             perr_hit;

  logic [8:0]       data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             par_err_q, par_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             uninit_q, uninit_d;
  logic             addr_err_q, addr_err_d;
  logic             coll_q, coll_d;

`ifdef PAR_MEM_INJECT_EN
  assign inj_bit = inj_par;
`else
  assign inj_bit = 1'b0;
`endif

  assign in_rng  = {1'b0, address} < DEPTH_L;
  assign wr_acc  = write & in_rng;
  // a simultaneous write wins; the read is dropped entirely
  assign rd_acc  = read & ~write;
  assign wr_idx  = address[IDX_W-1:0];
  assign wr_word = {(^data_in) ^ inj_bit, data_in};

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_idx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      written_q <= '0;
    else if (wr_acc) written_q[wr_idx] <= 1'b1;
  end

  // Address pipeline; the array is sampled when the read reaches the final stage.
  generate
    if (RD_LAT <= 1) begin : g_nolat
      assign fin_v   = rd_acc;
      assign fin_ok  = in_rng;
      assign fin_idx = wr_idx;
    end else begin : g_pipe
      logic [RD_LAT-2:0] pv_q;
      logic [RD_LAT-2:0] po_q;
      logic [IDX_W-1:0]  pi_q [RD_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pv_q <= '0;
          po_q <= '0;
          for (int i = 0; i < RD_LAT-1; i++) pi_q[i] <= '0;
        end else begin
          pv_q[0] <= rd_acc;
          po_q[0] <= in_rng;
          pi_q[0] <= wr_idx;
          for (int i = 1; i < RD_LAT-1; i++) begin
            pv_q[i] <= pv_q[i-1];
            po_q[i] <= po_q[i-1];
            pi_q[i] <= pi_q[i-1];
          end
        end
      end

      assign fin_v   = pv_q[RD_LAT-2];
      assign fin_ok  = po_q[RD_LAT-2];
      assign fin_idx = pi_q[RD_LAT-2];
    end
  endgenerate

  always_comb begin
    // forward a same-edge write so a pipelined read never returns stale data
    fwd        = wr_acc && (wr_idx == fin_idx);
    rd_word    = fwd ? wr_word : mem_q[fin_idx];
    rd_wr      = fwd | written_q[fin_idx];
    data_out_d = data_out_q;
    rd_valid_d = fin_v;
    uninit_d   = 1'b0;
    perr_hit   = 1'b0;
    if (fin_v) begin
      data_out_d = '0;
      if (fin_ok && rd_wr) begin
        data_out_d = rd_word;
        perr_hit   = ^rd_word;
      end else if (fin_ok) begin
        uninit_d = 1'b1;
      end
    end
    par_err_d = par_err_q | perr_hit;
    err_cnt_d = err_cnt_q;
    if (perr_hit && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
    addr_err_d = (write | read) & ~in_rng;
    coll_d     = write & read;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      uninit_q   <= 1'b0;
      addr_err_q <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      par_err_q  <= par_err_d;
      err_cnt_q  <= err_cnt_d;
      uninit_q   <= uninit_d;
      addr_err_q <= addr_err_d;
      coll_q     <= coll_d;
    end
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign par_err   = par_err_q;
  assign err_count = err_cnt_q;
  assign uninit_rd = uninit_q;
  assign addr_err  = addr_err_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_par_mem_resp.sv
// Randomised bench for par_mem_resp against a byte-array reference model of the responder.
// Runs with a reduced DEPTH so out-of-range addresses are reachable.
module tb_par_mem_resp;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 49152;
  localparam int RD_LAT = 1;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              write = 1'b0;
  logic              read = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [7:0]        data_in = '0;
  logic [8:0]        data_out;
  logic              rd_valid;
  logic              par_err;
  logic [CNT_W-1:0]  err_count;
  logic              uninit_rd;
  logic              addr_err;
  logic              collision;
`ifdef PAR_MEM_INJECT_EN
  logic              inj_par = 1'b0;
`endif

  par_mem_resp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .read(read), .address(address),
    .data_in(data_in),
`ifdef PAR_MEM_INJECT_EN
    .inj_par(inj_par),
`endif
    .data_out(data_out), .rd_valid(rd_valid), .par_err(par_err),
    .err_count(err_count), .uninit_rd(uninit_rd), .addr_err(addr_err),
    .collision(collision)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model: stored 9-bit words, written flags, pending reads
  typedef struct { int a; int due; } rd_t;
  logic [8:0] m_word [65536];
  bit         m_wr   [65536];
  rd_t        pq [$];
  logic [8:0] exp_do = '0;
  bit         exp_perr = 1'b0;
  int         exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock of stimulus followed by a full comparison of every output.
  task automatic step(input bit wr, input bit rd, input logic [15:0] a,
                      input logic [7:0] d, input bit inj);
    bit   exp_v, exp_u, exp_c, exp_ae, inj_eff;
    int   ai;
    rd_t  r;
    write = wr; read = rd; address = a; data_in = d;
`ifdef PAR_MEM_INJECT_EN
    inj_par = inj;
    inj_eff = inj;
`else
    inj_eff = 1'b0;
`endif
    @(posedge clk);
    cyc++;
    ai     = int'(a);
    exp_c  = wr && rd;
    exp_ae = (wr || rd) && (ai >= DEPTH);
    if (wr && ai < DEPTH) begin
      m_word[ai] = {(^d) ^ inj_eff, d};
      m_wr[ai]   = 1'b1;
    end
    if (rd && !wr) pq.push_back('{a: ai, due: cyc + RD_LAT - 1});
    exp_v = 1'b0;
    exp_u = 1'b0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      r = pq.pop_front();
      exp_v = 1'b1;
      if (r.a >= DEPTH) exp_do = '0;
      else if (!m_wr[r.a]) begin
        exp_do = '0;
        exp_u  = 1'b1;
      end else begin
        exp_do = m_word[r.a];
        if (^m_word[r.a]) begin
          exp_perr = 1'b1;
          if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
      end
    end
    #1;
    check("rd_valid",  32'(rd_valid),  32'(exp_v));
    check("data_out",  32'(data_out),  32'(exp_do));
    check("uninit_rd", 32'(uninit_rd), 32'(exp_u));
    check("collision", 32'(collision), 32'(exp_c));
    check("addr_err",  32'(addr_err),  32'(exp_ae));
    check("par_err",   32'(par_err),   32'(exp_perr));
    check("err_count", 32'(err_count), 32'(exp_cnt));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0);
  endtask

  task automatic wait_lat();
    repeat (RD_LAT - 1) idle();
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 16'hC000 + 16'($urandom_range(0, 7));
      1:       return 16'hBFF8 + 16'($urandom_range(0, 15));
      default: return 16'h0100 + 16'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    logic [15:0] addrs [6];
    logic [7:0]  datas [6];
    logic [7:0]  tmp;
    int          op;

    for (int i = 0; i < 65536; i++) m_wr[i] = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_data_out",  32'(data_out),  32'h0);
    check("rst_rd_valid",  32'(rd_valid),  32'h0);
    check("rst_par_err",   32'(par_err),   32'h0);
    check("rst_err_count", 32'(err_count), 32'h0);
    check("rst_uninit",    32'(uninit_rd), 32'h0);
    check("rst_addr_err",  32'(addr_err),  32'h0);
    check("rst_collision", 32'(collision), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // write then read back
    step(1'b1, 1'b0, 16'h1234, 8'hA5, 1'b0);
    step(1'b0, 1'b1, 16'h1234, 8'h00, 1'b0);
    wait_lat();
    check("t1_dout", 32'(data_out), 32'h0A5);
    check("t1_perr", 32'(par_err), 32'h0);

    // read on the cycle right after the write
    step(1'b1, 1'b0, 16'h0010, 8'h07, 1'b0);
    step(1'b0, 1'b1, 16'h0010, 8'h00, 1'b0);
    wait_lat();
    check("t2_dout", 32'(data_out), 32'h107);

    // six writes, then six back-to-back reads
    for (int i = 0; i < 6; i++) begin
      addrs[i] = 16'h2000 + 16'(i * 3);
      datas[i] = 8'($urandom);
      step(1'b1, 1'b0, addrs[i], datas[i], 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, addrs[i], 8'h00, 1'b0);
      if (RD_LAT == 1) begin
        tmp = datas[i];
        check("t3_dout", 32'(data_out), 32'({^tmp, tmp}));
      end
    end
    wait_lat();
    check("t3_cnt", 32'(err_count), 32'h0);

    // never-written location
    step(1'b0, 1'b1, 16'h4444, 8'h00, 1'b0);
    wait_lat();
    check("t4_dout", 32'(data_out), 32'h0);
    check("t4_uninit", 32'(uninit_rd), 32'h1);

    // collision: write wins, read dropped
    step(1'b1, 1'b1, 16'h0020, 8'h3C, 1'b0);
    check("t5_coll", 32'(collision), 32'h1);
    check("t5_nov", 32'(rd_valid), 32'h0);
    idle();
    step(1'b0, 1'b1, 16'h0020, 8'h00, 1'b0);
    wait_lat();
    check("t5_dout", 32'(data_out), 32'h03C);

    // out-of-range write ignored, read returns zero
    step(1'b1, 1'b0, 16'hC123, 8'h55, 1'b0);
    check("oor_wr_aerr", 32'(addr_err), 32'h1);
    step(1'b0, 1'b1, 16'hC123, 8'h00, 1'b0);
    check("oor_rd_aerr", 32'(addr_err), 32'h1);
    wait_lat();
    check("oor_dout", 32'(data_out), 32'h0);
    step(1'b1, 1'b0, 16'hBFFF, 8'h80, 1'b0);
    step(1'b0, 1'b1, 16'hBFFF, 8'h00, 1'b0);
    wait_lat();
    check("last_loc", 32'(data_out), 32'h180);

`ifdef PAR_MEM_INJECT_EN
    step(1'b1, 1'b0, 16'h0005, 8'h01, 1'b1);
    step(1'b0, 1'b1, 16'h0005, 8'h00, 1'b0);
    step(1'b0, 1'b1, 16'h0005, 8'h00, 1'b0);
    wait_lat();
    check("t6_dout", 32'(data_out), 32'h001);
    check("t6_perr", 32'(par_err), 32'h1);
    check("t6_cnt", 32'(err_count), 32'h2);
`endif

    // reset asserted while a read strobe is pending
    write = 1'b0; read = 1'b1; address = 16'h0005;
    #3;
    rst_n = 1'b0;
    #1;
    check("rr_perr", 32'(par_err), 32'h0);
    check("rr_cnt", 32'(err_count), 32'h0);
    @(posedge clk);
    #1;
    check("rr_nov", 32'(rd_valid), 32'h0);
    check("rr_dout", 32'(data_out), 32'h0);
    read = 1'b0;
    pq.delete();
    for (int i = 0; i < 65536; i++) m_wr[i] = 1'b0;
    exp_do = '0; exp_perr = 1'b0; exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h1234, 8'h00, 1'b0);
    wait_lat();
    check("rr_uninit", 32'(uninit_rd), 32'h1);

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 9));
      step(op <= 3 || op == 8, (op >= 4 && op <= 8), rand_addr(), 8'($urandom),
           ($urandom_range(0, 7) == 0));
    end
    repeat (RD_LAT + 1) idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
